// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Tagged BTB plus 2-bit PHT (bimodal or gshare) giving a
//               same-cycle fetch prediction and Execute-stage resolution.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int XLEN      = 32,
    parameter int BTB_IDX   = 4,
    parameter int PHT_IDX   = 6,
    parameter int HIST_BITS = 0,
    parameter int CNT_W     = 16,
    localparam int GH_W     = (HIST_BITS > 0) ? HIST_BITS : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  PCF,
    output logic             PredTakenF,
    output logic [XLEN-1:0]  PredTargetF,
    output logic [GH_W-1:0]  GhrF,
    input  logic             UpdateE,
    input  logic             JumpE,
    input  logic [XLEN-1:0]  PCE,
    input  logic [XLEN-1:0]  TargetE,
    input  logic             TakenE,
    input  logic             PredTakenE,
    input  logic [XLEN-1:0]  PredTargetE,
    input  logic [GH_W-1:0]  GhrE,
    output logic             MispredictE,
    output logic [XLEN-1:0]  CorrectPCE,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredictCount
);

    localparam int              c_BTB_N = 1 << BTB_IDX;
    localparam int              c_PHT_N = 1 << PHT_IDX;
    localparam int              c_TAG_W = XLEN - BTB_IDX - 2;
    localparam logic [XLEN-1:0] c_FOUR  = XLEN'(4);

    logic                r_btbValid  [c_BTB_N];
    logic [c_TAG_W-1:0]  r_btbTag    [c_BTB_N];
    logic [XLEN-1:0]     r_btbTarget [c_BTB_N];
    logic                r_btbJump   [c_BTB_N];
    logic [1:0]          r_pht       [c_PHT_N];
    logic [CNT_W-1:0]    r_branchCount;
    logic [CNT_W-1:0]    r_mispredictCount;
    logic [GH_W-1:0]     w_ghr;

    logic [BTB_IDX-1:0]  w_fIdx;
    logic [c_TAG_W-1:0]  w_fTag;
    logic [PHT_IDX-1:0]  w_fHist;
    logic [PHT_IDX-1:0]  w_fPhtIdx;
    logic                w_hit;
    logic [BTB_IDX-1:0]  w_eIdx;
    logic [c_TAG_W-1:0]  w_eTag;
    logic [PHT_IDX-1:0]  w_eHist;
    logic [PHT_IDX-1:0]  w_ePhtIdx;
    logic                w_mispredict;
    logic                w_unused;

    // History is zero-extended into the PHT index; bimodal ignores the carried copy.
    always_comb begin
        w_fHist = '0;
        w_fHist[GH_W-1:0] = w_ghr;
        w_eHist = '0;
        if (HIST_BITS > 0) begin
            w_eHist[GH_W-1:0] = GhrE;
        end
    end

    assign w_fIdx    = PCF[BTB_IDX+1:2];
    assign w_fTag    = PCF[XLEN-1:BTB_IDX+2];
    assign w_fPhtIdx = PCF[PHT_IDX+1:2] ^ w_fHist;
    assign w_hit     = r_btbValid[w_fIdx] && (r_btbTag[w_fIdx] == w_fTag);

    assign PredTakenF  = !rst && w_hit && (r_btbJump[w_fIdx] || r_pht[w_fPhtIdx][1]);
    assign PredTargetF = PredTakenF ? r_btbTarget[w_fIdx] : (PCF + c_FOUR);
    assign GhrF        = w_ghr;

    assign w_eIdx    = PCE[BTB_IDX+1:2];
    assign w_eTag    = PCE[XLEN-1:BTB_IDX+2];
    assign w_ePhtIdx = PCE[PHT_IDX+1:2] ^ w_eHist;

    assign w_mispredict = UpdateE &&
                          ((PredTakenE != TakenE) || (TakenE && (PredTargetE != TargetE)));
    assign MispredictE  = w_mispredict;
    assign CorrectPCE   = TakenE ? TargetE : (PCE + c_FOUR);

    assign BranchCount     = r_branchCount;
    assign MispredictCount = r_mispredictCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_BTB_N; i++) begin
                r_btbValid[i] <= 1'b0;
            end
            for (int i = 0; i < c_PHT_N; i++) begin
                r_pht[i] <= 2'b01;
            end
            r_branchCount     <= '0;
            r_mispredictCount <= '0;
        end else if (UpdateE) begin
            if (TakenE) begin
                r_btbValid[w_eIdx] <= 1'b1;
            end
            if (!JumpE) begin
                if (TakenE && (r_pht[w_ePhtIdx] != 2'b11)) begin
                    r_pht[w_ePhtIdx] <= r_pht[w_ePhtIdx] + 2'b01;
                end else if (!TakenE && (r_pht[w_ePhtIdx] != 2'b00)) begin
                    r_pht[w_ePhtIdx] <= r_pht[w_ePhtIdx] - 2'b01;
                end
            end
            if (r_branchCount != '1) begin
                r_branchCount <= r_branchCount + 1'b1;
            end
            if (w_mispredict && (r_mispredictCount != '1)) begin
                r_mispredictCount <= r_mispredictCount + 1'b1;
            end
        end
    end

    // Entry payload needs no reset: it is only observed through a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && UpdateE && TakenE) begin
            r_btbTag[w_eIdx]    <= w_eTag;
            r_btbTarget[w_eIdx] <= TargetE;
            r_btbJump[w_eIdx]   <= JumpE;
        end
    end

    if (HIST_BITS == 0) begin : g_ghrNone
        assign w_ghr = '0;
    end else if (HIST_BITS == 1) begin : g_ghrOne
        logic r_ghr;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ghr <= 1'b0;
            end else if (UpdateE && !JumpE) begin
                r_ghr <= TakenE;
            end
        end
        assign w_ghr = r_ghr;
    end else begin : g_ghrShift
        logic [GH_W-1:0] r_ghr;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ghr <= '0;
            end else if (UpdateE && !JumpE) begin
                r_ghr <= {r_ghr[GH_W-2:0], TakenE};
            end
        end
        assign w_ghr = r_ghr;
    end

    assign w_unused = &{1'b0, PCF[1:0], PCE[1:0], GhrE};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed bench for a bimodal instance and a gshare instance
//               (HIST_BITS=2, CNT_W=4) driven with shared resolve stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, PCE, TargetE;
    logic        UpdateE, JumpE, TakenE;
    logic        predTakenEA, predTakenEB;
    logic [31:0] predTargetEA, predTargetEB;
    logic [0:0]  ghrEA;
    logic [1:0]  ghrEB;

    logic        predTakenFA, predTakenFB, mispredictEA, mispredictEB;
    logic [31:0] predTargetFA, predTargetFB, correctPCEA, correctPCEB;
    logic [0:0]  ghrFA;
    logic [1:0]  ghrFB;
    logic [15:0] branchCountA, mispredictCountA;
    logic [3:0]  branchCountB, mispredictCountB;

    int          testsRun = 0;
    int          testsFailed = 0;
    logic        misA, misB;
    logic [31:0] corrA;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .BTB_IDX(4), .PHT_IDX(6), .HIST_BITS(0), .CNT_W(16)) u_dutA (
        .clk(clk), .rst(rst), .PCF(PCF),
        .PredTakenF(predTakenFA), .PredTargetF(predTargetFA), .GhrF(ghrFA),
        .UpdateE(UpdateE), .JumpE(JumpE), .PCE(PCE), .TargetE(TargetE), .TakenE(TakenE),
        .PredTakenE(predTakenEA), .PredTargetE(predTargetEA), .GhrE(ghrEA),
        .MispredictE(mispredictEA), .CorrectPCE(correctPCEA),
        .BranchCount(branchCountA), .MispredictCount(mispredictCountA)
    );

    branch_predictor #(.XLEN(32), .BTB_IDX(4), .PHT_IDX(6), .HIST_BITS(2), .CNT_W(4)) u_dutB (
        .clk(clk), .rst(rst), .PCF(PCF),
        .PredTakenF(predTakenFB), .PredTargetF(predTargetFB), .GhrF(ghrFB),
        .UpdateE(UpdateE), .JumpE(JumpE), .PCE(PCE), .TargetE(TargetE), .TakenE(TakenE),
        .PredTakenE(predTakenEB), .PredTargetE(predTargetEB), .GhrE(ghrEB),
        .MispredictE(mispredictEB), .CorrectPCE(correctPCEB),
        .BranchCount(branchCountB), .MispredictCount(mispredictCountB)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic lookup(input logic [31:0] pc);
        PCF = pc;
        #1;
    endtask

    // Fetch the branch, carry each instance's own prediction to E, resolve it.
    task automatic doBranch(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic taken, input logic jump);
        PCF = pc;
        #1;
        predTakenEA  = predTakenFA;
        predTargetEA = predTargetFA;
        ghrEA        = ghrFA;
        predTakenEB  = predTakenFB;
        predTargetEB = predTargetFB;
        ghrEB        = ghrFB;
        UpdateE = 1'b1; PCE = pc; TargetE = tgt; TakenE = taken; JumpE = jump;
        #1;
        misA  = mispredictEA;
        corrA = correctPCEA;
        misB  = mispredictEB;
        @(posedge clk);
        #1;
        UpdateE = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        UpdateE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; PCF = '0; PCE = '0; TargetE = '0;
        UpdateE = 1'b0; JumpE = 1'b0; TakenE = 1'b0;
        predTakenEA = 1'b0; predTakenEB = 1'b0;
        predTargetEA = '0; predTargetEB = '0; ghrEA = '0; ghrEB = '0;
        doReset();

        lookup(32'h100);
        checkVal("rst_taken", predTakenFA, 0);
        checkVal("rst_target", predTargetFA, 32'h104);
        checkVal("rst_brcnt", branchCountA, 0);
        checkVal("rst_miscnt", mispredictCountA, 0);
        checkVal("rst_miscntB", mispredictCountB, 0);

        // Conditional branch 0x40 -> 0x80 trains bimodal counter up to 3
        doBranch(32'h40, 32'h80, 1'b1, 1'b0);
        checkVal("br1_mis", misA, 1);
        checkVal("br1_corr", corrA, 32'h80);
        doBranch(32'h40, 32'h80, 1'b1, 1'b0);
        checkVal("br2_mis", misA, 0);
        lookup(32'h40);
        checkVal("br_lk_taken", predTakenFA, 1);
        checkVal("br_lk_target", predTargetFA, 32'h80);
        checkVal("br_miscnt", mispredictCountA, 1);
        doBranch(32'h40, 32'h80, 1'b0, 1'b0);
        checkVal("brN_mis", misA, 1);
        checkVal("brN_corr", corrA, 32'h44);
        lookup(32'h40);
        checkVal("brN_still_taken", predTakenFA, 1);

        // JAL then JALR with a different target
        doBranch(32'h20, 32'h200, 1'b1, 1'b1);
        checkVal("jal_mis", misA, 1);
        doBranch(32'h20, 32'h300, 1'b1, 1'b1);
        checkVal("jalr_mis", misA, 1);
        checkVal("jalr_corr", corrA, 32'h300);
        lookup(32'h20);
        checkVal("jalr_lk_taken", predTakenFA, 1);
        checkVal("jalr_lk_target", predTargetFA, 32'h300);

        // 0x80 aliases 0x40 in a 16-entry BTB
        doBranch(32'h80, 32'h500, 1'b1, 1'b0);
        checkVal("alias_mis", misA, 1);
        lookup(32'h40);
        checkVal("alias_40_taken", predTakenFA, 0);
        checkVal("alias_40_target", predTargetFA, 32'h44);
        lookup(32'h80);
        checkVal("alias_80_taken", predTakenFA, 1);
        checkVal("alias_80_target", predTargetFA, 32'h500);
        checkVal("cnt_br", branchCountA, 6);
        checkVal("cnt_mis", mispredictCountA, 5);

        // No update: no mispredict, corrected PC still follows TakenE
        PCE = 32'h40; TargetE = 32'h777; TakenE = 1'b1; predTakenEA = 1'b0; UpdateE = 1'b0;
        #1;
        checkVal("idle_mis", mispredictEA, 0);
        checkVal("idle_corr", correctPCEA, 32'h777);

        // Reset with a coincident jump update: the update must be dropped
        PCF = 32'h80;
        rst = 1'b1; UpdateE = 1'b1; PCE = 32'h20; TargetE = 32'h900; TakenE = 1'b1; JumpE = 1'b1;
        @(posedge clk);
        #1;
        checkVal("inrst_taken", predTakenFA, 0);
        checkVal("inrst_target", predTargetFA, 32'h84);
        rst = 1'b0; UpdateE = 1'b0;
        @(posedge clk);
        #1;
        lookup(32'h20);
        checkVal("postrst_taken", predTakenFA, 0);
        checkVal("postrst_target", predTargetFA, 32'h24);
        checkVal("postrst_brcnt", branchCountA, 0);
        checkVal("postrst_brcntB", branchCountB, 0);

        // gshare learns an alternating T/N branch
        doReset();
        for (int i = 0; i < 12; i++) begin
            doBranch(32'h60, 32'h10, (i % 2) == 0, 1'b0);
            if (i >= 8) checkVal($sformatf("gsh_mis_%0d", i), misB, 0);
        end
        checkVal("gsh_ghrB", ghrFB, 2);
        checkVal("gsh_ghrA", ghrFA, 0);
        checkVal("gsh_brcntB", branchCountB, 12);
        checkVal("gsh_miscntB", mispredictCountB, 2);

        // 20 jump mispredicts saturate the 4-bit counters
        for (int i = 0; i < 20; i++) begin
            doBranch(32'h100, 32'h1000 + 32'(i * 16), 1'b1, 1'b1);
        end
        lookup(32'h100);
        checkVal("sat_targetB", predTargetFB, 32'h1130);
        checkVal("sat_miscntB", mispredictCountB, 15);
        checkVal("sat_brcntB", branchCountB, 15);
        checkVal("nosat_brcntA", branchCountA, 32);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
`default_nettype wire
